ipsl_pcie_dma_rx_mrd_rd_ctrl: RTL and testbench

IPSL_PCIE_DMA_RX_MRD_RD_CTRL -- requirements
Module: ipsl_pcie_dma_rx_mrd_rd_ctrl

---
 rtl/ipsl_pcie_dma_rx_mrd_rd_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ipsl_pcie_dma_rx_mrd_rd_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_dma_rx_mrd_rd_ctrl.sv
// MRd read controller: fetches RAM words for a memory-read request and emits DW-masked completion beats.
// Optional BAR filter is compiled in with `define IPSL_PCIE_DMA_RD_BAR_FILTER_EN.
module ipsl_pcie_dma_rx_mrd_rd_ctrl #(
    parameter int         ADDR_WIDTH = 9,
    parameter logic [1:0] BAR_SEL    = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mrd_rd_start,
    input  logic [9:0]            i_mrd_length,
    input  logic [63:0]           i_mrd_addr,
    input  logic [1:0]            i_bar_hit,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [127:0]          i_rd_data,
    output logic                  o_cpld_vld,
    input  logic                  i_cpld_rdy,
    output logic [127:0]          o_cpld_data,
    output logic [3:0]            o_cpld_dw_vld,
    output logic                  o_cpld_last,
    output logic                  o_busy,
    output logic                  o_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  start_ok;
    logic [10:0]           len_eff;
    logic [1:0]            req_off;
    logic [10:0]           beat_sum;
    logic [8:0]            req_beats;

    logic                  rd_en_q;
    logic                  rd_ret_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [8:0]            reads_left;
    logic [8:0]            wr_left;
    logic                  wr_first;
    logic [1:0]            off_q;
    logic [1:0]            end_q;
    logic                  drop_q;

    logic [127:0]          fifo_data [4];
    logic [3:0]            fifo_mask [4];
    logic [3:0]            fifo_last;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_cnt;

    logic                  fifo_vld;
    logic                  pop;
    logic                  room;
    logic                  issue;
    logic [3:0]            first_mask;
    logic [3:0]            last_mask;
    logic [3:0]            wr_mask;

    assign len_eff   = (i_mrd_length == 10'd0) ? 11'd1024 : {1'b0, i_mrd_length};
    assign req_off   = i_mrd_addr[3:2];
    assign beat_sum  = len_eff + {9'd0, req_off} + 11'd3;
    assign req_beats = beat_sum[10:2];

`ifdef IPSL_PCIE_DMA_RD_BAR_FILTER_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, i_mrd_addr[63:ADDR_WIDTH+4], i_mrd_addr[1:0]};
    assign start_ok  = i_mrd_rd_start && (state == IDLE) && (i_bar_hit == BAR_SEL);
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, i_mrd_addr[63:ADDR_WIDTH+4], i_mrd_addr[1:0], i_bar_hit ^ BAR_SEL};
    assign start_ok  = i_mrd_rd_start && (state == IDLE);
`endif

    // Every issued read already owns a FIFO slot: buffered + returning + issuing must stay below 4.
    assign room     = ({1'b0, fifo_cnt} + {3'd0, rd_en_q} + {3'd0, rd_ret_q}) < 4'd4;
    assign issue    = (state == READ) && (reads_left != 9'd0) && room;
    assign fifo_vld = (fifo_cnt != 3'd0);
    assign pop      = fifo_vld && i_cpld_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = READ;
            READ:    if (reads_left == 9'd0) state_nxt = DRAIN;
            DRAIN:   if (pop && fifo_last[rd_ptr]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first read issues straight from the accept edge so the first beat is ready two edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q    <= 1'b0;
            rd_ret_q   <= 1'b0;
            rd_addr_q  <= '0;
            reads_left <= 9'd0;
            wr_left    <= 9'd0;
            wr_first   <= 1'b0;
            off_q      <= 2'd0;
            end_q      <= 2'd0;
            drop_q     <= 1'b0;
        end else begin
            drop_q   <= i_mrd_rd_start && !start_ok;
            rd_ret_q <= rd_en_q;
            if (start_ok) begin
                rd_en_q    <= 1'b1;
                rd_addr_q  <= i_mrd_addr[ADDR_WIDTH+3:4];
                reads_left <= req_beats - 9'd1;
                off_q      <= req_off;
                end_q      <= req_off + i_mrd_length[1:0];
            end else if (issue) begin
                rd_en_q    <= 1'b1;
                rd_addr_q  <= rd_addr_q + ADDR_WIDTH'(1);
                reads_left <= reads_left - 9'd1;
            end else begin
                rd_en_q    <= 1'b0;
            end
            if (start_ok) begin
                wr_left  <= req_beats;
                wr_first <= 1'b1;
            end else if (rd_ret_q) begin
                wr_left  <= wr_left - 9'd1;
                wr_first <= 1'b0;
            end
        end
    end

    // Masks are attached as each word enters the FIFO, so the output side only replays them.
    assign first_mask = 4'hF << off_q;

    always_comb begin
        last_mask = 4'hF;
        unique case (end_q)
            2'd1:    last_mask = 4'b0001;
            2'd2:    last_mask = 4'b0011;
            2'd3:    last_mask = 4'b0111;
            default: last_mask = 4'hF;
        endcase
    end

    assign wr_mask = (wr_first ? first_mask : 4'hF) & ((wr_left == 9'd1) ? last_mask : 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            fifo_cnt  <= 3'd0;
            fifo_last <= 4'd0;
        end else begin
            if (rd_ret_q) begin
                wr_ptr            <= wr_ptr + 2'd1;
                fifo_last[wr_ptr] <= (wr_left == 9'd1);
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'd0, rd_ret_q} - {2'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rd_ret_q) begin
            fifo_data[wr_ptr] <= i_rd_data;
            fifo_mask[wr_ptr] <= wr_mask;
        end
    end

    assign o_rd_en       = rd_en_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_cpld_vld    = fifo_vld;
    assign o_cpld_data   = fifo_vld ? fifo_data[rd_ptr] : 128'd0;
    assign o_cpld_dw_vld = fifo_vld ? fifo_mask[rd_ptr] : 4'd0;
    assign o_cpld_last   = fifo_vld && fifo_last[rd_ptr];
    assign o_busy        = (state != IDLE);
    assign o_drop        = drop_q;

endmodule

// File: tb/tb_ipsl_pcie_dma_rx_mrd_rd_ctrl.sv
// Randomised self-checking bench for ipsl_pcie_dma_rx_mrd_rd_ctrl with a DW-level reference model and RAM model.
// Exercises the BAR filter when IPSL_PCIE_DMA_RD_BAR_FILTER_EN is defined.
module tb_ipsl_pcie_dma_rx_mrd_rd_ctrl;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    len;
    logic [63:0]   addr;
    logic [1:0]    bar;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data;
    logic          vld;
    logic          rdy;
    logic [127:0]  data;
    logic [3:0]    mask;
    logic          last;
    logic          busy;
    logic          drop;

    always #5 clk = ~clk;

    ipsl_pcie_dma_rx_mrd_rd_ctrl #(.ADDR_WIDTH(AW), .BAR_SEL(2'b01)) dut (
        .clk(clk), .rst(rst),
        .i_mrd_rd_start(start), .i_mrd_length(len), .i_mrd_addr(addr), .i_bar_hit(bar),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_cpld_vld(vld), .i_cpld_rdy(rdy), .o_cpld_data(data),
        .o_cpld_dw_vld(mask), .o_cpld_last(last), .o_busy(busy), .o_drop(drop)
    );

    logic [127:0] ram [512];

    // RAM model: one-cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int n_cmp = 0;
    int n_fail = 0;

    logic [127:0] exp_data[$], obs_data[$];
    logic [3:0]   exp_mask[$], obs_mask[$];
    bit           exp_last[$], obs_last[$];
    int n_issued, n_xfer, max_out, stable_err, first_vld, drops, first_rd_addr;
    logic busy_after;

    // Reference: a request covers DWs off..off+L-1 starting at word base; each beat holds 4 DWs.
    task automatic build_model(input logic [63:0] a, input logic [9:0] l);
        int L, off, base, beats;
        logic [3:0] m;
        exp_data.delete(); exp_mask.delete(); exp_last.delete();
        L     = (l == 10'd0) ? 1024 : int'(l);
        off   = int'(a[3:2]);
        base  = int'(a[12:4]);
        beats = (off + L + 3) / 4;
        for (int i = 0; i < beats; i++) begin
            for (int j = 0; j < 4; j++) m[j] = ((4*i + j) >= off) && ((4*i + j) < off + L);
            exp_data.push_back(ram[(base + i) % 512]);
            exp_mask.push_back(m);
            exp_last.push_back(i == beats - 1);
        end
    endtask

    task automatic run_request(input logic [63:0] a, input logic [9:0] l, input int mode,
                               input int inject, input bit no_wait);
        int budget;
        bit held, done;
        logic [132:0] hv;
        obs_data.delete(); obs_mask.delete(); obs_last.delete();
        n_issued = 0; n_xfer = 0; max_out = 0; stable_err = 0; first_vld = -1; drops = 0;
        first_rd_addr = -1; busy_after = 1'b1; done = 0; held = 0; hv = '0;
        build_model(a, l);
        budget = exp_data.size() * 8 + 40;
        if (!no_wait) @(negedge clk);
        start = 1'b1; addr = a; len = l; rdy = (mode == 0);
        @(posedge clk);
        for (int c = 1; c <= budget && !done; c++) begin
            @(negedge clk);
            start = (c == inject);
            if (c == inject) begin
                addr = {$urandom, $urandom};
                len  = 10'($urandom);
            end
            if (drop) drops++;
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (c % 2 == 1);
            else                rdy = ($urandom_range(0, 2) != 0);
            if (rd_en) begin
                if (first_rd_addr < 0) first_rd_addr = int'(rd_addr);
                n_issued++;
            end
            if (vld && first_vld < 0) first_vld = c;
            if (held && (!vld || {last, mask, data} !== hv)) stable_err++;
            if (n_issued - n_xfer > max_out) max_out = n_issued - n_xfer;
            held = vld && !rdy;
            hv   = {last, mask, data};
            if (vld && rdy) begin
                obs_data.push_back(data); obs_mask.push_back(mask); obs_last.push_back(last);
                n_xfer++;
                if (last) done = 1;
            end
        end
        if (done) begin
            @(negedge clk);
            busy_after = busy;
            if (drop) drops++;
        end else begin
            $display("[TB] request timed out after %0d cycles", budget);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (rd_en !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset rd_en: got %b, expected 0", rd_en); end
        n_cmp++; if (rd_addr !== '0)   begin n_fail++; $display("[TB] FAIL reset rd_addr: got %h, expected 0", rd_addr); end
        n_cmp++; if (vld !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset cpld_vld: got %b, expected 0", vld); end
        n_cmp++; if (data !== '0)      begin n_fail++; $display("[TB] FAIL reset cpld_data: got %h, expected 0", data); end
        n_cmp++; if (mask !== 4'd0)    begin n_fail++; $display("[TB] FAIL reset dw_vld: got %b, expected 0", mask); end
        n_cmp++; if (last !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset last: got %b, expected 0", last); end
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
        n_cmp++; if (drop !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset drop: got %b, expected 0", drop); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({vld, busy, rd_en} !== 3'b000) begin n_fail++; $display("[TB] FAIL post-reset idle: got %b, expected 000", {vld, busy, rd_en}); end
    endtask

    task automatic test_directed;
        logic [63:0] a_tab [3];
        logic [9:0]  l_tab [3];
        a_tab[0] = 64'h100;  l_tab[0] = 10'd4;
        a_tab[1] = 64'h104;  l_tab[1] = 10'd6;
        a_tab[2] = 64'h1FF0; l_tab[2] = 10'd8;
        for (int t = 0; t < 3; t++) begin
            run_request(a_tab[t], l_tab[t], 0, 0, 0);
            n_cmp++; if (obs_data.size() != exp_data.size()) begin n_fail++; $display("[TB] FAIL directed%0d beats: got %0d, expected %0d", t, obs_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                n_cmp++;
                if ({obs_last[i], obs_mask[i], obs_data[i]} !== {exp_last[i], exp_mask[i], exp_data[i]}) begin
                    n_fail++;
                    $display("[TB] FAIL directed%0d beat %0d: got last=%0b mask=%b data=%h, expected last=%0b mask=%b data=%h",
                             t, i, obs_last[i], obs_mask[i], obs_data[i], exp_last[i], exp_mask[i], exp_data[i]);
                end
            end
            n_cmp++; if (first_rd_addr != int'(a_tab[t][12:4])) begin n_fail++; $display("[TB] FAIL directed%0d rd_addr: got %h, expected %h", t, first_rd_addr, a_tab[t][12:4]); end
            n_cmp++; if (first_vld != 3) begin n_fail++; $display("[TB] FAIL directed%0d latency: got %0d, expected 3", t, first_vld); end
            n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL directed%0d busy after last: got %b, expected 0", t, busy_after); end
        end
    endtask

    task automatic test_full_length;
        logic [63:0] bases [2];
        bases[0] = 64'h0; bases[1] = 64'h1FF0;
        for (int t = 0; t < 2; t++) begin
            run_request(bases[t], 10'd0, 0, 0, 0);
            n_cmp++; if (obs_data.size() != 256) begin n_fail++; $display("[TB] FAIL len1024_%0d beats: got %0d, expected 256", t, obs_data.size()); end
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                n_cmp++;
                if ({obs_last[i], obs_mask[i], obs_data[i]} !== {exp_last[i], exp_mask[i], exp_data[i]}) begin
                    n_fail++;
                    $display("[TB] FAIL len1024_%0d beat %0d: got last=%0b mask=%b data=%h, expected last=%0b mask=%b data=%h",
                             t, i, obs_last[i], obs_mask[i], obs_data[i], exp_last[i], exp_mask[i], exp_data[i]);
                end
            end
            n_cmp++; if (max_out > 4) begin n_fail++; $display("[TB] FAIL len1024_%0d outstanding: got %0d, expected <=4", t, max_out); end
        end
    endtask

    task automatic test_toggle_rdy;
        run_request({$urandom, $urandom} & ~64'hC, 10'd16, 1, 0, 0);
        n_cmp++; if (obs_data.size() != 4) begin n_fail++; $display("[TB] FAIL toggle beats: got %0d, expected 4", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if ({obs_last[i], obs_mask[i], obs_data[i]} !== {exp_last[i], exp_mask[i], exp_data[i]}) begin
                n_fail++;
                $display("[TB] FAIL toggle beat %0d: got last=%0b mask=%b data=%h, expected last=%0b mask=%b data=%h",
                         i, obs_last[i], obs_mask[i], obs_data[i], exp_last[i], exp_mask[i], exp_data[i]);
            end
        end
        n_cmp++; if (max_out > 4)     begin n_fail++; $display("[TB] FAIL toggle outstanding: got %0d, expected <=4", max_out); end
        n_cmp++; if (stable_err != 0) begin n_fail++; $display("[TB] FAIL toggle stability: got %0d changes, expected 0", stable_err); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a;
        logic [9:0]  l;
        run_request({$urandom, $urandom}, 10'd16, 0, 2, 0);
        n_cmp++; if (drops != 1) begin n_fail++; $display("[TB] FAIL busy_start drop pulses: got %0d, expected 1", drops); end
        n_cmp++; if (obs_data.size() != exp_data.size()) begin n_fail++; $display("[TB] FAIL busy_start beats: got %0d, expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if ({obs_last[i], obs_mask[i], obs_data[i]} !== {exp_last[i], exp_mask[i], exp_data[i]}) begin
                n_fail++;
                $display("[TB] FAIL busy_start beat %0d: got last=%0b mask=%b data=%h, expected last=%0b mask=%b data=%h",
                         i, obs_last[i], obs_mask[i], obs_data[i], exp_last[i], exp_mask[i], exp_data[i]);
            end
        end
        a = {$urandom, $urandom};
        l = 10'($urandom_range(1, 40));
        run_request(a, l, 0, 0, 1);
        n_cmp++; if (obs_data.size() != exp_data.size()) begin n_fail++; $display("[TB] FAIL b2b beats: got %0d, expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if ({obs_last[i], obs_mask[i], obs_data[i]} !== {exp_last[i], exp_mask[i], exp_data[i]}) begin
                n_fail++;
                $display("[TB] FAIL b2b beat %0d: got last=%0b mask=%b data=%h, expected last=%0b mask=%b data=%h",
                         i, obs_last[i], obs_mask[i], obs_data[i], exp_last[i], exp_mask[i], exp_data[i]);
            end
        end
        n_cmp++; if (first_vld != 3) begin n_fail++; $display("[TB] FAIL b2b latency: got %0d, expected 3", first_vld); end
    endtask

    task automatic test_random;
        logic [63:0] a;
        logic [9:0]  l;
        for (int t = 0; t < 10; t++) begin
            a = {$urandom, $urandom};
            l = (t == 4) ? 10'd0 : 10'($urandom_range(1, 100));
            run_request(a, l, 2, 0, 0);
            n_cmp++; if (obs_data.size() != exp_data.size()) begin n_fail++; $display("[TB] FAIL random%0d beats: got %0d, expected %0d", t, obs_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                n_cmp++;
                if ({obs_last[i], obs_mask[i], obs_data[i]} !== {exp_last[i], exp_mask[i], exp_data[i]}) begin
                    n_fail++;
                    $display("[TB] FAIL random%0d beat %0d: got last=%0b mask=%b data=%h, expected last=%0b mask=%b data=%h",
                             t, i, obs_last[i], obs_mask[i], obs_data[i], exp_last[i], exp_mask[i], exp_data[i]);
                end
            end
            n_cmp++; if (first_vld != 3)  begin n_fail++; $display("[TB] FAIL random%0d latency: got %0d, expected 3", t, first_vld); end
            n_cmp++; if (max_out > 4)     begin n_fail++; $display("[TB] FAIL random%0d outstanding: got %0d, expected <=4", t, max_out); end
            n_cmp++; if (stable_err != 0) begin n_fail++; $display("[TB] FAIL random%0d stability: got %0d changes, expected 0", t, stable_err); end
        end
    endtask

    task automatic test_bar_filter;
        int seen;
        bar = 2'b10;
`ifdef IPSL_PCIE_DMA_RD_BAR_FILTER_EN
        seen = 0;
        @(negedge clk);
        start = 1'b1; addr = 64'h200; len = 10'd8; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (drop !== 1'b1) begin n_fail++; $display("[TB] FAIL bar drop: got %b, expected 1", drop); end
        for (int c = 0; c < 8; c++) begin
            if (rd_en || vld || busy) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("[TB] FAIL bar activity: got %0d active cycles, expected 0", seen); end
`else
        seen = 0;
        run_request(64'h200, 10'd8, 0, 0, 0);
        seen = obs_data.size();
        n_cmp++; if (seen != 2) begin n_fail++; $display("[TB] FAIL bar ignored beats: got %0d, expected 2", seen); end
        n_cmp++; if (drops != 0) begin n_fail++; $display("[TB] FAIL bar ignored drop: got %0d, expected 0", drops); end
`endif
        bar = 2'b01;
    endtask

    task automatic test_reset_mid;
        int xfers, seen;
        xfers = 0; seen = 0;
        @(negedge clk);
        start = 1'b1; addr = 64'h300; len = 10'd32; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && xfers < 2; c++) begin
            if (vld && rdy) xfers++;
            if (xfers < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rd_en, rd_addr, vld, data, mask, last, busy, drop} !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid-reset outputs: got rd_en=%b vld=%b busy=%b data=%h, expected all 0", rd_en, vld, busy, data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (vld || rd_en) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("[TB] FAIL after mid-reset activity: got %0d cycles, expected 0", seen); end
        run_request(64'h400, 10'd12, 0, 0, 0);
        n_cmp++; if (obs_data.size() != 3) begin n_fail++; $display("[TB] FAIL recovery beats: got %0d, expected 3", obs_data.size()); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; addr = '0; bar = 2'b01; rdy = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset;
        test_directed;
        test_full_length;
        test_toggle_rdy;
        test_back_to_back;
        test_random;
        test_bar_filter;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
